// File: rtl/riscv_pkg.sv
// Shared types for the multi-cycle RISC-V controller: ALU control codes, opcodes,
// FSM states and datapath mux encodings.
package riscv_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_OR  = 4'b0011,
    ALU_XOR = 4'b0100,
    ALU_SLL = 4'b0101,
    ALU_SRL = 4'b0110
  } alu_ctrl_e;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10
  } mc_state_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    logic [1:0] imm;
    case (op)
      OP_SW:     imm = IMM_S;
      OP_BRANCH: imm = IMM_B;
      OP_JAL:    imm = IMM_J;
      default:   imm = IMM_I;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/riscv_mc_controller_alu_decoder.sv
// Combinational ALUOp/funct decode to the 4-bit ALU control code, plus a flag for
// funct3/funct7b5 combinations the ALU does not support.
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output alu_ctrl_e  alu_control,
  output logic       illegal
);

  // Unsupported funct encodings, independent of ALUOp so DECODE can screen R/I ops
  always_comb begin
    illegal = 1'b0;
    case (funct3)
      3'b010, 3'b011:  illegal = 1'b1;
      3'b001, 3'b101:  illegal = funct7b5;
      default:         illegal = 1'b0;
    endcase
  end

  // ALU operation selection
  always_comb begin
    alu_control = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000: begin
            if (op5 && funct7b5) begin
              alu_control = ALU_SUB;
            end else begin
              alu_control = ALU_ADD;
            end
          end
          3'b001:  alu_control = ALU_SLL;
          3'b100:  alu_control = ALU_XOR;
          3'b101: begin
            if (!funct7b5) begin
              alu_control = ALU_SRL;
            end else begin
              alu_control = ALU_ADD;
            end
          end
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/riscv_mc_controller.sv
// Multi-cycle RISC-V control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared ALU and memory port.
module riscv_mc_controller
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [3:0] ALUControl,
  output logic       IllegalInstr
);

  mc_state_e  state_r;
  mc_state_e  state_next_s;
  logic [1:0] aluop_s;
  alu_ctrl_e  alu_control_s;
  logic       funct_illegal_s;
  logic       instr_illegal_s;
  logic       pcwrite_s;
  logic       memwrite_s;
  logic       irwrite_s;
  logic       regwrite_s;
  logic       illegal_pulse_s;

  alu_decoder u_alu_decoder (
    .aluop       (aluop_s),
    .funct3      (funct3),
    .op5         (op[5]),
    .funct7b5    (funct7b5),
    .alu_control (alu_control_s),
    .illegal     (funct_illegal_s)
  );

  // Whole-instruction legality; funct fields matter only for R/I and branch ops
  always_comb begin
    instr_illegal_s = 1'b0;
    case (op)
      OP_LW, OP_SW, OP_JAL: instr_illegal_s = 1'b0;
      OP_RTYPE, OP_ITYPE:   instr_illegal_s = funct_illegal_s;
      OP_BRANCH: begin
        if (funct3 == F3_BEQ || funct3 == F3_BNE) begin
          instr_illegal_s = 1'b0;
        end else begin
          instr_illegal_s = 1'b1;
        end
      end
      default: instr_illegal_s = 1'b1;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_next_s = S_FETCH;
    case (state_r)
      S_FETCH: state_next_s = S_DECODE;
      S_DECODE: begin
        if (instr_illegal_s) begin
          state_next_s = S_FETCH;
        end else begin
          case (op)
            OP_LW, OP_SW: state_next_s = S_MEMADR;
            OP_RTYPE:     state_next_s = S_EXECUTER;
            OP_ITYPE:     state_next_s = S_EXECUTEI;
            OP_BRANCH:    state_next_s = S_BRANCH;
            OP_JAL:       state_next_s = S_JAL;
            default:      state_next_s = S_FETCH;
          endcase
        end
      end
      S_MEMADR: begin
        if (op == OP_SW) begin
          state_next_s = S_MEMWRITE;
        end else begin
          state_next_s = S_MEMREAD;
        end
      end
      S_MEMREAD:  state_next_s = S_MEMWB;
      S_EXECUTER: state_next_s = S_ALUWB;
      S_EXECUTEI: state_next_s = S_ALUWB;
      S_JAL:      state_next_s = S_ALUWB;
      default:    state_next_s = S_FETCH;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Moore outputs per state; BRANCH alone looks at Zero
  always_comb begin
    pcwrite_s       = 1'b0;
    AdrSrc          = 1'b0;
    memwrite_s      = 1'b0;
    irwrite_s       = 1'b0;
    regwrite_s      = 1'b0;
    ResultSrc       = RES_ALUOUT;
    ALUSrcA         = SRCA_PC;
    ALUSrcB         = SRCB_RD2;
    aluop_s         = ALUOP_ADD;
    illegal_pulse_s = 1'b0;
    case (state_r)
      S_FETCH: begin
        irwrite_s = 1'b1;
        pcwrite_s = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      S_DECODE: begin
        ALUSrcA         = SRCA_OLDPC;
        ALUSrcB         = SRCB_IMM;
        illegal_pulse_s = instr_illegal_s;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc  = RES_DATA;
        regwrite_s = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        memwrite_s = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = SRCA_RD1;
        aluop_s = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        aluop_s = ALUOP_FUNCT;
      end
      S_ALUWB: regwrite_s = 1'b1;
      S_BRANCH: begin
        ALUSrcA = SRCA_RD1;
        aluop_s = ALUOP_SUB;
        if (funct3 == F3_BNE) begin
          pcwrite_s = ~Zero;
        end else begin
          pcwrite_s = Zero;
        end
      end
      S_JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        pcwrite_s = 1'b1;
      end
      default: begin
        pcwrite_s = 1'b0;
      end
    endcase
  end

  // Write enables held off for the whole time reset is asserted
  assign PCWrite      = pcwrite_s & ~reset;
  assign MemWrite     = memwrite_s & ~reset;
  assign IRWrite      = irwrite_s & ~reset;
  assign RegWrite     = regwrite_s & ~reset;
  assign IllegalInstr = illegal_pulse_s & ~reset;
  assign ALUControl   = alu_control_s;
  assign ImmSrc       = imm_src_of(op);

endmodule

// File: tb/tb_riscv_mc_controller.sv
// Scoreboard bench for riscv_mc_controller: stimulus queues expected per-cycle
// control vectors, a negedge monitor pops and compares them.
module tb_riscv_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, IllegalInstr;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [3:0] ALUControl;

  typedef struct {
    string       name;
    logic [17:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  riscv_mc_controller dut (
    .clk          (clk),
    .reset        (reset),
    .op           (op),
    .funct3       (funct3),
    .funct7b5     (funct7b5),
    .Zero         (Zero),
    .PCWrite      (PCWrite),
    .AdrSrc       (AdrSrc),
    .MemWrite     (MemWrite),
    .IRWrite      (IRWrite),
    .RegWrite     (RegWrite),
    .ResultSrc    (ResultSrc),
    .ALUSrcA      (ALUSrcA),
    .ALUSrcB      (ALUSrcB),
    .ImmSrc       (ImmSrc),
    .ALUControl   (ALUControl),
    .IllegalInstr (IllegalInstr)
  );

  always #5 clk = ~clk;

  // Vector order: PCWrite AdrSrc MemWrite IRWrite RegWrite ResultSrc SrcA SrcB ImmSrc ALUControl Illegal
  always @(negedge clk) begin
    logic [17:0] act;
    exp_t        e;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
             ALUSrcB, ImmSrc, ALUControl, IllegalInstr};
      checks++;
      if (act !== e.v) begin
        errors++;
        $display("FAIL %s: got %b required %b", e.name, act, e.v);
      end
    end
  end

  task automatic push(input string n, input logic pcw, adr, mw, irw, rw,
                      input logic [1:0] res, sa, sb, imm,
                      input logic [3:0] alu, input logic ill);
    exp_t e;
    e.name = n;
    e.v    = {pcw, adr, mw, irw, rw, res, sa, sb, imm, alu, ill};
    exp_q.push_back(e);
  endtask

  task automatic e_fetch(input string n, input logic [1:0] imm);
    push({n, " FETCH"}, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, imm, 4'b0000, 1'b0);
  endtask

  task automatic e_fetch_rst(input string n, input logic [1:0] imm);
    push({n, " RESET"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, imm, 4'b0000, 1'b0);
  endtask

  task automatic e_decode(input string n, input logic [1:0] imm, input logic ill);
    push({n, " DECODE"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, imm, 4'b0000, ill);
  endtask

  task automatic e_memadr(input string n, input logic [1:0] imm);
    push({n, " MEMADR"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, imm, 4'b0000, 1'b0);
  endtask

  task automatic e_aluwb(input string n, input logic [1:0] imm);
    push({n, " ALUWB"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, imm, 4'b0000, 1'b0);
  endtask

  task automatic issue(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
    op       = o;
    funct3   = f3;
    funct7b5 = f7;
    Zero     = z;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] i_f3  [6] = '{3'b100, 3'b001, 3'b101, 3'b110, 3'b111, 3'b000};
    logic       i_f7  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [3:0] i_alu [6] = '{4'b0100, 4'b0101, 4'b0110, 4'b0011, 4'b0010, 4'b0000};
    logic [2:0] b_f3  [4] = '{3'b000, 3'b000, 3'b001, 3'b001};
    logic       b_z   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic       b_pcw [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    reset = 1'b1;
    issue(7'b0000011, 3'b010, 1'b0, 1'b0);
    e_fetch_rst("init", 2'b00);
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    // lw: 5 cycles
    issue(7'b0000011, 3'b010, 1'b0, 1'b1);
    e_fetch("lw", 2'b00);
    e_decode("lw", 2'b00, 1'b0);
    e_memadr("lw", 2'b00);
    push("lw MEMREAD", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 1'b0);
    push("lw MEMWB", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 4'b0000, 1'b0);
    cycles(5);

    // sw: 4 cycles
    issue(7'b0100011, 3'b010, 1'b0, 1'b0);
    e_fetch("sw", 2'b01);
    e_decode("sw", 2'b01, 1'b0);
    e_memadr("sw", 2'b01);
    push("sw MEMWRITE", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 4'b0000, 1'b0);
    cycles(4);

    // R-type sub: 4 cycles
    issue(7'b0110011, 3'b000, 1'b1, 1'b1);
    e_fetch("sub", 2'b00);
    e_decode("sub", 2'b00, 1'b0);
    push("sub EXECUTER", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, 4'b0001, 1'b0);
    e_aluwb("sub", 2'b00);
    cycles(4);

    // I-type ALU ops, including funct3=000 with funct7b5=1 (still ADD)
    for (int i = 0; i < 6; i++) begin
      issue(7'b0010011, i_f3[i], i_f7[i], 1'b0);
      e_fetch($sformatf("itype%0d", i), 2'b00);
      e_decode($sformatf("itype%0d", i), 2'b00, 1'b0);
      push($sformatf("itype%0d EXECUTEI", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10,
           2'b01, 2'b00, i_alu[i], 1'b0);
      e_aluwb($sformatf("itype%0d", i), 2'b00);
      cycles(4);
    end

    // jal: 4 cycles, Zero high must not matter
    issue(7'b1101111, 3'b000, 1'b0, 1'b1);
    e_fetch("jal", 2'b11);
    e_decode("jal", 2'b11, 1'b0);
    push("jal JAL", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b11, 4'b0000, 1'b0);
    e_aluwb("jal", 2'b11);
    cycles(4);

    // beq/bne with both Zero values: 3 cycles
    for (int i = 0; i < 4; i++) begin
      issue(7'b1100011, b_f3[i], 1'b0, b_z[i]);
      e_fetch($sformatf("br%0d", i), 2'b10);
      e_decode($sformatf("br%0d", i), 2'b10, 1'b0);
      push($sformatf("br%0d BRANCH", i), b_pcw[i], 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10,
           2'b00, 2'b10, 4'b0001, 1'b0);
      cycles(3);
    end

    // Illegal instructions: 2 cycles, pulse in DECODE only
    issue(7'b0110111, 3'b000, 1'b0, 1'b0);
    e_fetch("lui", 2'b00);
    e_decode("lui", 2'b00, 1'b1);
    cycles(2);
    issue(7'b0110011, 3'b010, 1'b0, 1'b0);
    e_fetch("slt", 2'b00);
    e_decode("slt", 2'b00, 1'b1);
    cycles(2);
    issue(7'b0010011, 3'b101, 1'b1, 1'b0);
    e_fetch("srai", 2'b00);
    e_decode("srai", 2'b00, 1'b1);
    cycles(2);
    issue(7'b1100011, 3'b100, 1'b0, 1'b1);
    e_fetch("blt", 2'b10);
    e_decode("blt", 2'b10, 1'b1);
    cycles(2);

    // Reset in the middle of lw's MEMREAD
    issue(7'b0000011, 3'b010, 1'b0, 1'b0);
    e_fetch("lwr", 2'b00);
    e_decode("lwr", 2'b00, 1'b0);
    e_memadr("lwr", 2'b00);
    push("lwr MEMREAD", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 1'b0);
    cycles(3);
    @(negedge clk);
    #1 reset = 1'b1;
    e_fetch_rst("lwr", 2'b00);
    e_fetch_rst("lwr", 2'b00);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Recovery: sw runs normally after reset
    issue(7'b0100011, 3'b010, 1'b0, 1'b0);
    e_fetch("sw2", 2'b01);
    e_decode("sw2", 2'b01, 1'b0);
    e_memadr("sw2", 2'b01);
    push("sw2 MEMWRITE", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 4'b0000, 1'b0);
    cycles(4);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_mc_controller.md
# riscv_mc_controller

Multi-cycle control FSM that drives the datapath and the `alu` block: it sequences fetch/decode/execute/memory/writeback and issues the 4-bit ALUControl code the ALU consumes. It is the initiator side of the ALU control interface. It lets the datapath share one ALU and one memory port across cycles. Combinational ALU-code decoding is split into a sub-module.

## Interface
Parameters: none.
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; FSM to FETCH
- op  in  7  instruction opcode, Instr[6:0], from the instruction register
- funct3  in  3  Instr[14:12]
- funct7b5  in  1  Instr[30]
- Zero  in  1  ALU zero flag
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address: 0=PC, 1=ALUOut
- MemWrite  out  1  data memory write enable
- IRWrite  out  1  instruction/OldPC register enable
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=RD1
- ALUSrcB  out  2  00=RD2, 01=ImmExt, 10=constant 4
- ImmSrc  out  2  00=I, 01=S, 10=B, 11=J; combinational from op
- ALUControl  out  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL
- IllegalInstr  out  1  one-cycle pulse in DECODE for an unsupported instruction

## Operation
- Supported ops: lw 0000011, sw 0100011, R-type 0110011, I-ALU 0010011, branch 1100011 (beq funct3=000, bne 001), jal 1101111.
- ALUOp (internal, 2 bits): 00 gives ADD, 01 gives SUB, 10 decodes funct3:
  - 000: ADD, or SUB when op[5]=1 and funct7b5=1
  - 001: SLL
  - 100: XOR
  - 101: SRL, only with funct7b5=0
  - 110: OR
  - 111: AND
- The decoder flags as illegal: funct3 010/011, funct3 101 with funct7b5=1, funct3 001 with funct7b5=1, and any unlisted opcode or branch funct3.
- States and asserted outputs. Unlisted outputs are 0 or 00.
  - FETCH: IRWrite, PCWrite, AdrSrc=0, SrcA=00, SrcB=10, ADD, ResultSrc=10. Next state is DECODE.
  - DECODE: SrcA=01, SrcB=01, ADD (branch target into ALUOut). Next state by op: lw/sw go to MEMADR, R goes to EXECUTER, I goes to EXECUTEI, branch goes to BRANCH, jal goes to JAL. Illegal pulses IllegalInstr and goes to FETCH.
  - MEMADR: SrcA=10, SrcB=01, ADD. Next state is MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD: AdrSrc=1, ResultSrc=00. Next state is MEMWB.
  - MEMWB: ResultSrc=01, RegWrite. Next state is FETCH.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite. Next state is FETCH.
  - EXECUTER: SrcA=10, SrcB=00, ALUOp=10. Next state is ALUWB.
  - EXECUTEI: SrcA=10, SrcB=01, ALUOp=10. Next state is ALUWB.
  - ALUWB: ResultSrc=00, RegWrite. Next state is FETCH.
  - BRANCH: SrcA=10, SrcB=00, SUB, ResultSrc=00. PCWrite=Zero for beq, ~Zero for bne. Next state is FETCH.
  - JAL: SrcA=01, SrcB=10, ADD, ResultSrc=00, PCWrite. Next state is ALUWB.
- ImmSrc decodes from op in every state: lw/I give 00, sw gives 01, branch gives 10, jal gives 11, others give 00.

## Timing
- Moore FSM with a single state register. All outputs are combinational from state, op, funct3, funct7b5 and Zero. Zero is used only in BRANCH.
- Cycles per instruction, FETCH to FETCH: lw 5, sw 4, R 4, I 4, branch 3, jal 4, illegal 2.
- Reset: the state resets asynchronously to FETCH. While reset=1, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0. The other outputs show FETCH values, and IllegalInstr=0.
- After reset falls, the first rising edge performs the FETCH writes.
- Reset asserted in any state aborts the instruction; no further write enables assert.
- Zero toggling outside BRANCH has no effect. In BRANCH, PCWrite follows Zero in the same cycle.
- IllegalInstr is exactly one cycle wide. The PC has already advanced by 4 in FETCH, so the instruction is skipped.

## Structure
- Package riscv_pkg holds:
  - alu_ctrl_e: the 4-bit ALUControl enum shared with `alu`
  - opcode localparams
  - state enum mc_state_e
  - encodings for ResultSrc, ALUSrcA, ALUSrcB and ImmSrc
- Sub-module alu_decoder: combinational, inputs ALUOp, funct3, op[5] and funct7b5; outputs ALUControl and an illegal flag. The FSM instantiates it once.

## Test plan
- Reset mid-MEMREAD of lw (op=0000011) → state FETCH at once, RegWrite stays 0, write enables 0 throughout reset.
- Apply lw, sw, R-type (funct3=000, funct7b5=1), I-type and jal in turn → cycle counts 5/4/4/4/4. The R-type issues ALUControl=0001 in EXECUTER, and RegWrite is asserted only in MEMWB/ALUWB.
- beq with Zero=1 → PCWrite=1 in BRANCH. Same with Zero=0 → PCWrite=0. bne inverts both.
- I-type with funct3 100/001/101/110/111 → ALUControl 0100/0101/0110/0011/0010 in EXECUTEI.
- op=0110111, then R-type with funct3=010 → IllegalInstr pulses one cycle in DECODE, the next state is FETCH, and no RegWrite or MemWrite occurs.
- jal → JAL state: SrcA=01, SrcB=10, PCWrite=1; ALUWB follows with ResultSrc=00, RegWrite=1; ImmSrc=11 throughout.
